// File: rtl/datapath_pkg.sv
// datapath_pkg: shared opcode and FSM encodings for the datapath register file.
//   op_e    : instruction opcodes (3 bits)
//   state_e : control FSM states (IDLE, MUL)
package datapath_pkg;

  typedef enum logic [2:0] {
    OP_PASSB = 3'd0,
    OP_NOTA  = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_AND   = 3'd4,
    OP_OR    = 3'd5,
    OP_XOR   = 3'd6,
    OP_MUL   = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/datapath_alu.sv
// datapath_alu: combinational single-cycle ALU.
//   a, b   : operands (WIDTH)
//   op     : opcode; OP_MUL is not handled here and yields result=0, carry=0
//   result : operation result, modulo 2^WIDTH
//   carry  : ADD carry-out, SUB borrow (a<b), 0 for logic ops
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_PASSB: result = b;
      OP_NOTA:  result = ~a;
      OP_ADD:   {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      default:  ; // multiply runs in the sequential unit
    endcase
  end

endmodule

// File: rtl/datapath_rf.sv
// datapath_rf: register file with single-cycle ALU ops and a WIDTH-cycle
// shift-and-add multiplier.
//   clk, rst_n        : clock, async active-low reset
//   go                : start an instruction (ignored while busy)
//   op_sel            : opcode (see datapath_pkg::op_e)
//   dst, src_a, src_b : register indices
//   imm, imm_sel      : immediate and B-operand select (1 = imm)
//   dbg_addr/dbg_data : combinational register read port
//   busy              : multiply in progress
//   done              : one-cycle pulse after each register write
//   zero, carry       : flags of the last written result
module datapath_rf
  import datapath_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [2:0]       op_sel,
  input  logic [AW-1:0]    dst,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic [WIDTH-1:0] imm,
  input  logic             imm_sel,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry
);

  // Counter only needs to hold WIDTH-1.
  localparam int CW = $clog2(WIDTH);

  logic [NREGS-1:0][WIDTH-1:0] regs;
  state_e                      state, state_nxt;
  logic [CW-1:0]               cnt;
  logic [2*WIDTH-1:0]          acc, mcand, acc_nxt;
  logic [WIDTH-1:0]            mplier;
  logic [AW-1:0]               mul_dst;

  op_e              op;
  logic [WIDTH-1:0] a_val, b_val, alu_res;
  logic             alu_c, start, mul_last;

  assign op       = op_e'(op_sel);
  assign a_val    = regs[src_a];
  assign b_val    = imm_sel ? imm : regs[src_b];
  assign dbg_data = regs[dbg_addr];
  assign busy     = (state == ST_MUL);
  assign start    = go && (state == ST_IDLE);
  assign mul_last = (state == ST_MUL) && (cnt == '0);
  // One multiplier bit per busy cycle; the last step is written straight
  // from acc_nxt so the write lands on the edge ending the last busy cycle.
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

  datapath_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_val),
    .b      (b_val),
    .op     (op),
    .result (alu_res),
    .carry  (alu_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start && op == OP_MUL) state_nxt = ST_MUL;
      ST_MUL:  if (mul_last)              state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs    <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      mul_dst <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        if (op == OP_MUL) begin
          acc     <= '0;
          mcand   <= {{WIDTH{1'b0}}, a_val};
          mplier  <= b_val;
          mul_dst <= dst;
          cnt     <= CW'(WIDTH - 1);
        end else begin
          regs[dst] <= alu_res;
          zero      <= (alu_res == '0);
          carry     <= alu_c;
          done      <= 1'b1;
        end
      end else if (state == ST_MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (mul_last) begin
          regs[mul_dst] <= acc_nxt[WIDTH-1:0];
          zero          <= (acc_nxt[WIDTH-1:0] == '0);
          carry         <= |acc_nxt[2*WIDTH-1:WIDTH];
          done          <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_datapath_rf.sv
// tb_datapath_rf: scoreboard bench for datapath_rf (WIDTH=8, NREGS=4).
module tb_datapath_rf;

  logic       clk = 1'b0, rst_n = 1'b0, go = 1'b0, imm_sel = 1'b0;
  logic [2:0] op_sel = '0;
  logic [1:0] dst = '0, src_a = '0, src_b = '0, dbg_addr = '0;
  logic [7:0] imm = '0;
  logic [7:0] dbg_data;
  logic       busy, done, zero, carry;

  typedef struct {
    logic [1:0] dst;
    logic [7:0] val;
    logic       z;
    logic       c;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mregs[4] = '{default: 8'h00};
  int         n_chk = 0, n_bad = 0;

  datapath_rf #(.WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .op_sel(op_sel), .dst(dst),
    .src_a(src_a), .src_b(src_b), .imm(imm), .imm_sel(imm_sel),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy), .done(done),
    .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference arithmetic, written directly from the opcode definitions.
  function automatic void model(input logic [2:0] op, input logic [7:0] a, b,
                                output logic [7:0] r, output logic c);
    logic [15:0] p;
    c = 1'b0;
    r = 8'h00;
    case (op)
      3'd0: r = b;
      3'd1: r = ~a;
      3'd2: begin p = 16'(a) + 16'(b); r = p[7:0]; c = p[8]; end
      3'd3: begin r = a - b; c = (a < b); end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: begin p = 16'(a) * 16'(b); r = p[7:0]; c = (p[15:8] != 0); end
    endcase
  endfunction

  // Drive one go and push its expected outcome to the scoreboard.
  task automatic drive(input logic [2:0] op, input logic [1:0] d, sa, sbi,
                       input logic [7:0] im, input logic isel);
    exp_t e;
    logic [7:0] r;
    logic c;
    op_sel = op; dst = d; src_a = sa; src_b = sbi; imm = im; imm_sel = isel;
    go = 1'b1;
    model(op, mregs[sa], isel ? im : mregs[sbi], r, c);
    e.dst = d; e.val = r; e.z = (r == 8'h00); e.c = c;
    sb.push_back(e);
    mregs[d] = r;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] d, sa, sbi,
                       input logic [7:0] im, input logic isel);
    drive(op, d, sa, sbi, im, isel);
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int lat);
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, done, zero, carry} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got=%b want=0000", {busy, done, zero, carry});
    end
    for (int r = 0; r < 4; r++) begin
      dbg_addr = 2'(r); #1; n_chk++;
      if (dbg_data !== 8'h00) begin
        n_bad++; $display("FAIL reset_reg%0d got=%h want=00", r, dbg_data);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_passb;
    exp_t e; bit ok; int lat;
    issue(3'd0, 2'd1, 2'd0, 2'd0, 8'd5, 1'b1);
    wait_done(ok, lat);
    e = sb.pop_front(); dbg_addr = e.dst; #1; n_chk++;
    if (!ok || lat != 1 || {dbg_data, zero, carry} !== {e.val, e.z, e.c}) begin
      n_bad++; $display("FAIL passb ok=%0d lat=%0d got=%h z%b c%b want=%h z%b c%b",
                        ok, lat, dbg_data, zero, carry, e.val, e.z, e.c);
    end
    @(negedge clk); n_chk++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL passb_done_width got=%b want=0", done); end
  endtask

  task automatic test_add_sub_nota;
    exp_t e; bit ok; int lat;
    // ADD 5+251 wraps to 0 with carry; SUB 5-6 borrows; NOTA with dst==src_a.
    logic [2:0] ops[3]  = '{3'd2, 3'd3, 3'd1};
    logic [1:0] dsts[3] = '{2'd2, 2'd3, 2'd3};
    logic [1:0] sas[3]  = '{2'd1, 2'd1, 2'd3};
    logic [7:0] ims[3]  = '{8'd251, 8'd6, 8'd0};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], dsts[i], sas[i], 2'd0, ims[i], 1'b1);
      wait_done(ok, lat);
      e = sb.pop_front(); dbg_addr = e.dst; #1; n_chk++;
      if (!ok || lat != 1 || {dbg_data, zero, carry} !== {e.val, e.z, e.c}) begin
        n_bad++; $display("FAIL alu_op%0d ok=%0d lat=%0d got=%h z%b c%b want=%h z%b c%b",
                          ops[i], ok, lat, dbg_data, zero, carry, e.val, e.z, e.c);
      end
    end
  endtask

  task automatic test_mul_busy;
    exp_t e; int nb = 0, extra = 0;
    drive(3'd7, 2'd0, 2'd1, 2'd0, 8'd13, 1'b1);
    @(posedge clk);
    #1 go = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      // ADD in the 3rd busy cycle and PASSB in the last one: both ignored.
      op_sel = (nb == 8) ? 3'd0 : 3'd2;
      dst = 2'd1; src_a = 2'd1; imm = 8'd99; imm_sel = 1'b1;
      go = (nb == 3 || nb == 8);
    end
    go = 1'b0;
    e = sb.pop_front(); dbg_addr = e.dst; #1; n_chk++;
    if (nb != 8 || done !== 1'b1 || {dbg_data, zero, carry} !== {e.val, e.z, e.c}) begin
      n_bad++; $display("FAIL mul busy=%0d done=%b got=%h z%b c%b want busy=8 done=1 %h z%b c%b",
                        nb, done, dbg_data, zero, carry, e.val, e.z, e.c);
    end
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (done) extra++; end
    n_chk++;
    if (extra != 0) begin n_bad++; $display("FAIL mul_extra_done got=%0d want=0", extra); end
    for (int r = 0; r < 4; r++) begin
      dbg_addr = 2'(r); #1; n_chk++;
      if (dbg_data !== mregs[r]) begin
        n_bad++; $display("FAIL mul_reg%0d got=%h want=%h", r, dbg_data, mregs[r]);
      end
    end
  endtask

  task automatic test_mul_overflow;
    exp_t e; bit ok; int lat;
    issue(3'd0, 2'd1, 2'd0, 2'd0, 8'd16, 1'b1);
    wait_done(ok, lat);
    void'(sb.pop_front());
    issue(3'd7, 2'd0, 2'd1, 2'd0, 8'd16, 1'b1);
    wait_done(ok, lat);
    e = sb.pop_front(); dbg_addr = e.dst; #1; n_chk++;
    if (!ok || lat != 9 || {dbg_data, zero, carry} !== {e.val, e.z, e.c}) begin
      n_bad++; $display("FAIL mul_ovf ok=%0d lat=%0d got=%h z%b c%b want lat=9 %h z%b c%b",
                        ok, lat, dbg_data, zero, carry, e.val, e.z, e.c);
    end
  endtask

  task automatic test_reset_mid_mul;
    exp_t e; bit ok; int lat, nb = 0, dn = 0;
    op_sel = 3'd7; dst = 2'd3; src_a = 2'd1; imm = 8'd3; imm_sel = 1'b1; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    for (int i = 0; i < 20 && nb < 4; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    rst_n = 1'b0;
    #1; n_chk++;
    if (nb != 4 || {busy, done, zero, carry} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_mid_mul nb=%0d flags=%b want nb=4 flags=0000",
                        nb, {busy, done, zero, carry});
    end
    for (int r = 0; r < 4; r++) begin
      mregs[r] = 8'h00;
      dbg_addr = 2'(r); #1; n_chk++;
      if (dbg_data !== 8'h00) begin
        n_bad++; $display("FAIL rst_mid_reg%0d got=%h want=00", r, dbg_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (done || busy) dn++; end
    n_chk++;
    if (dn != 0) begin n_bad++; $display("FAIL rst_mid_no_done got=%0d want=0", dn); end
    issue(3'd0, 2'd2, 2'd0, 2'd0, 8'd7, 1'b1);
    wait_done(ok, lat);
    e = sb.pop_front(); dbg_addr = e.dst; #1; n_chk++;
    if (!ok || lat != 1 || {dbg_data, zero, carry} !== {e.val, e.z, e.c}) begin
      n_bad++; $display("FAIL rst_resume ok=%0d lat=%0d got=%h z%b c%b want=%h z%b c%b",
                        ok, lat, dbg_data, zero, carry, e.val, e.z, e.c);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int n = 16;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front(); dbg_addr = e.dst; #1; n_chk++;
        if (done !== 1'b1 || {dbg_data, zero, carry} !== {e.val, e.z, e.c}) begin
          n_bad++; $display("FAIL b2b_%0d done=%b got=%h z%b c%b want=%h z%b c%b",
                            i, done, dbg_data, zero, carry, e.val, e.z, e.c);
        end
      end
      if (i < n)
        drive(3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      else
        go = 1'b0;
    end
    for (int r = 0; r < 4; r++) begin
      dbg_addr = 2'(r); #1; n_chk++;
      if (dbg_data !== mregs[r]) begin
        n_bad++; $display("FAIL b2b_reg%0d got=%h want=%h", r, dbg_data, mregs[r]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_passb;
    test_add_sub_nota;
    test_mul_busy;
    test_mul_overflow;
    test_reset_mid_mul;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
